// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch FSM state encoding
//   DEFAULT_RESET_PC : default PC loaded at reset
//   DEFAULT_NOP_INST : default instruction presented when nothing is valid
//   PC_INCR          : sequential PC increment (one 32-bit word)
//   word_align()     : clears the two low address bits
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // out of reset, no request yet
    ST_FETCH = 2'd1,  // request outstanding, response will be used
    ST_HOLD  = 2'd2,  // instruction presented, waiting for consumption
    ST_FLUSH = 2'd3   // request outstanding, response will be thrown away
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_INCR          = 32'h0000_0004;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC selection.
//   clk, rst    : clock, synchronous active-low reset (loads RESET_PC)
//   redirect    : take redirect_pc (word-aligned) as the next PC
//   redirect_pc : redirect target, low two bits ignored
//   advance     : a fetch completed; next PC is base + 4
//   base        : address of the fetch that completed
//   pc_next     : value the PC takes at the coming edge
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  input  logic [31:0] base,
  output logic [31:0] pc_next
);

  logic [31:0] pc;

  // Redirect wins over the sequential increment; the add wraps modulo 2^32.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = word_align(redirect_pc);
    end else if (advance) begin
      pc_next = base + PC_INCR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit.
// Issues one word request at a time, presents the returned instruction to
// decode until it is consumed (stall low) and follows downstream redirects,
// discarding any response that belongs to a superseded request.
//   clk, rst      : clock, synchronous active-low reset
//   imem_req      : request to instruction memory, high until response
//   imem_addr     : word-aligned request address, stable while imem_req
//   imem_rdata    : instruction word, qualified by imem_valid
//   imem_valid    : one-cycle response strobe
//   redirect      : taken branch/jump from downstream
//   redirect_pc   : redirect target
//   stall         : decode cannot accept inst this cycle
//   inst, inst_pc : instruction to decode and its address
//   inst_valid    : inst/inst_pc hold a live instruction
//   misalign      : one-cycle pulse when redirect_pc[1:0] was non-zero
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign
);

  fetch_state_e state, next_state;
  logic [31:0]  req_addr;
  logic [31:0]  pc_next;
  logic         advance;   // fetch completed, PC moves to req_addr + 4
  logic         load_req;  // entering FETCH, capture the new request address
  logic         deliver;   // response accepted into the output register
  logic         consume;   // presented instruction retired or flushed

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .base        (req_addr),
    .pc_next     (pc_next)
  );

  assign imem_addr = req_addr;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    advance    = 1'b0;
    load_req   = 1'b0;
    deliver    = 1'b0;
    consume    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A redirect here only moves pc; pc_next already carries it.
        next_state = ST_FETCH;
        load_req   = 1'b1;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_valid) begin
            // Response lands with the redirect: drop it, re-request at once.
            load_req = 1'b1;
          end else begin
            next_state = ST_FLUSH;
          end
        end else if (imem_valid) begin
          deliver    = 1'b1;
          advance    = 1'b1;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) begin
          consume    = 1'b1;
          load_req   = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        // Old request stays on the bus until its response drains. A redirect
        // coinciding with the drain is still honoured via pc_next.
        imem_req = 1'b1;
        if (imem_valid) begin
          load_req   = 1'b1;
          next_state = ST_FETCH;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_addr   <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= 32'h0000_0000;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state    <= next_state;
      misalign <= redirect & (|redirect_pc[1:0]);
      if (load_req) begin
        req_addr <= pc_next;
      end
      if (deliver) begin
        inst       <= imem_rdata;
        inst_pc    <= req_addr;
        inst_valid <= 1'b1;
      end else if (consume) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misalign;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- memory model ----------------
  int          lat_cfg = 1;
  bit          lat_rand = 0;
  bit          rand_spurious = 0;
  bit          inject_valid = 0;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          n_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Called at the falling edge; rst is the value the last rising edge saw.
  task automatic mem_step();
    if (!rst) begin
      mem_busy   = 0;
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (imem_valid) imem_valid = 1'b0;
      if (mem_busy) begin
        check("addr_stable", imem_addr, mem_addr);
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 0;
        end
      end else if (imem_req) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
        n_req++;
      end
    end
    if (inject_valid) begin
      imem_valid   = 1'b1;
      imem_rdata   = $urandom;
      inject_valid = 0;
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the fetch unit as "has it started", "is a request live",
  // "will the live response be dropped" and the presented instruction.
  bit          m_started, m_live, m_drop, m_ivalid, m_mis;
  logic [31:0] m_pc, m_addr, m_inst, m_inst_pc;
  bit          model_chk = 0;

  task automatic model_step();
    logic [31:0] tgt;
    if (!rst) begin
      m_started = 0; m_live = 0; m_drop = 0; m_ivalid = 0; m_mis = 0;
      m_pc = RST_PC; m_addr = RST_PC; m_inst = NOP; m_inst_pc = 32'h0;
    end else begin
      tgt   = redirect ? (redirect_pc & 32'hFFFF_FFFC) : m_pc;
      m_mis = redirect && (redirect_pc % 4 != 0);
      if (!m_started) begin
        m_started = 1; m_live = 1; m_pc = tgt; m_addr = tgt;
      end else if (m_live) begin
        if (imem_valid && !m_drop && !redirect) begin
          m_inst = imem_rdata; m_inst_pc = m_addr; m_ivalid = 1;
          m_pc = m_addr + 32'd4; m_live = 0;
        end else if (imem_valid) begin
          m_drop = 0; m_pc = tgt; m_addr = tgt;
        end else begin
          m_pc = tgt;
          if (redirect) m_drop = 1;
        end
      end else begin
        m_pc = tgt;
        if (redirect || !stall) begin
          m_ivalid = 0; m_inst = NOP; m_live = 1; m_addr = tgt;
        end
      end
    end
  endtask

  task automatic model_compare();
    check("m_req", imem_req, m_live);
    if (m_live) check("m_addr", imem_addr, m_addr);
    check("m_inst_valid", inst_valid, m_ivalid);
    check("m_inst", inst, m_inst);
    if (m_ivalid) check("m_inst_pc", inst_pc, m_inst_pc);
    check("m_misalign", misalign, m_mis);
  endtask

  // One clock: memory reacts, inputs applied, edge, sample at falling edge.
  task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] rp);
    mem_step();
    if (rand_spurious && !mem_busy && !imem_valid && !imem_req && $urandom_range(0, 9) == 0) begin
      imem_valid = 1'b1;
      imem_rdata = $urandom;
    end
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_chk) model_compare();
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20 && !inst_valid; k++) cycle(1, 1, 0, 32'h0);
    check(name, inst_valid, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          r, s, rd;
    logic [31:0] rp;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_inst, e_ipc;
    bit          e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit e_req, logic [31:0] e_addr, bit e_iv,
                              logic [31:0] e_inst, logic [31:0] e_ipc);
    vec_t v;
    v.r = r; v.s = s; v.rd = 0; v.rp = 32'h0;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_mis = 0;
    return v;
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;

    // Reset, first fetch with latency 1, five-cycle stall, next fetch at 0x4.
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, NOP, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, NOP, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h0, 0, NOP, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h0, 0, NOP, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h0050_0093, 32'h0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 1, 0, 32'h0, 1, 32'h0050_0093, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h4, 0, NOP, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h4, 0, NOP, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0, 1, mem_word(32'h4), 32'h4));

    @(negedge clk);
    lat_cfg = 1;
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].rp);
      check($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("v%0d_inst_valid", i), inst_valid, tbl[i].e_iv);
      check($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
      if (tbl[i].e_iv) check($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
      check($sformatf("v%0d_misalign", i), misalign, tbl[i].e_mis);
    end
    check("req_count", n_req, 2);

    // Latency 3, redirect one cycle after the request to 0x8 -> flush.
    lat_cfg = 3;
    cycle(1, 0, 0, 32'h0);
    check("fl_req8", imem_req, 1'b1);
    check("fl_addr8", imem_addr, 32'h8);
    cycle(1, 0, 1, 32'h100);
    check("fl_hold_addr", imem_addr, 32'h8);
    check("fl_hold_req", imem_req, 1'b1);
    cycle(1, 0, 0, 32'h0);
    check("fl_wait1_addr", imem_addr, 32'h8);
    cycle(1, 0, 0, 32'h0);
    check("fl_wait2_addr", imem_addr, 32'h8);
    cycle(1, 0, 0, 32'h0);
    check("fl_new_req", imem_req, 1'b1);
    check("fl_new_addr", imem_addr, 32'h100);
    check("fl_no_inst", inst_valid, 1'b0);
    wait_valid("fl_timeout");
    check("fl_inst_pc", inst_pc, 32'h100);
    check("fl_inst", inst, mem_word(32'h100));

    // Misaligned redirect in HOLD, taking priority over stall.
    cycle(1, 1, 1, 32'h202);
    check("mis_pulse", misalign, 1'b1);
    check("mis_inst_valid", inst_valid, 1'b0);
    check("mis_inst", inst, NOP);
    check("mis_addr", imem_addr, 32'h200);
    cycle(1, 1, 0, 32'h0);
    check("mis_pulse_end", misalign, 1'b0);
    wait_valid("mis_timeout");
    check("mis_inst_pc", inst_pc, 32'h200);

    // Wrap of the sequential PC.
    cycle(1, 1, 1, 32'hFFFF_FFFC);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wrap_no_mis", misalign, 1'b0);
    wait_valid("wrap_timeout");
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 32'h0);
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr_zero", imem_addr, 32'h0);

    // Reset while flushing, with late responses during and at release.
    cycle(1, 1, 1, 32'h40);
    check("rf_flush_addr", imem_addr, 32'h0);
    cycle(0, 1, 0, 32'h0);
    check("rf_req", imem_req, 1'b0);
    check("rf_inst_valid", inst_valid, 1'b0);
    check("rf_inst", inst, NOP);
    check("rf_inst_pc", inst_pc, 32'h0);
    check("rf_addr", imem_addr, RST_PC);
    inject_valid = 1;
    cycle(0, 1, 0, 32'h0);
    check("rf_late_req", imem_req, 1'b0);
    check("rf_late_inst", inst, NOP);
    check("rf_late_valid", inst_valid, 1'b0);
    inject_valid = 1;
    cycle(1, 1, 0, 32'h0);
    check("rf_rel_req", imem_req, 1'b1);
    check("rf_rel_addr", imem_addr, RST_PC);
    check("rf_rel_inst_valid", inst_valid, 1'b0);
    wait_valid("rf_timeout");
    check("rf_inst_pc0", inst_pc, RST_PC);
    check("rf_inst0", inst, 32'h0050_0093);

    // Randomized run against the model.
    lat_rand = 1;
    rand_spurious = 1;
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    model_chk = 1;
    for (int n = 0; n < 3000; n++) begin
      bit          r, s, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rp = $urandom & 32'h0000_0FFF;
      cycle(r, s, rd, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): inst value whenever no valid instruction is presented.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  request to instruction memory; held high until the response is returned.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word; meaningful only when imem_valid=1.
REQ-008 imem_valid  input  1  one-cycle response strobe; latency 1 or more cycles after the request.
REQ-009 redirect  input  1  taken branch/jal/jalr from downstream; overrides sequential PC.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 stall  input  1  downstream decode/controller cannot accept inst this cycle.
REQ-012 inst  output  32  instruction to decode (opcode [6:0], func3 [14:12], func7 bit [30]).
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst_valid  output  1  inst/inst_pc hold a live instruction.
REQ-015 misalign  output  1  one-cycle pulse: redirect_pc[1:0] was non-zero.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HOLD and FLUSH.
REQ-017 IDLE SHALL go to FETCH on the first cycle with rst=1; imem_req SHALL be 0 in IDLE.
REQ-018 FETCH: imem_req=1, imem_addr=req_addr (captured from pc on FETCH entry).
REQ-019 FETCH, imem_valid=1, redirect=0: inst<=imem_rdata, inst_pc<=req_addr, inst_valid<=1, pc<=req_addr+4, next state HOLD.
REQ-020 HOLD with stall=0 counts as consumption: inst_valid<=0, inst<=NOP_INST, next state FETCH, new request on the following cycle.
REQ-021 HOLD with stall=1: all outputs held unchanged; there is no stall limit.
REQ-022 Throughput is one instruction per (memory latency + 2) cycles; no second request is outstanding.
REQ-023 redirect SHALL have priority over stall and imem_valid: pc<=redirect_pc & ~32'h3; misalign<=|redirect_pc[1:0].
REQ-024 Redirect in HOLD: inst_valid<=0, inst<=NOP_INST, next state FETCH.
REQ-025 Redirect in FETCH with imem_valid=1 in the same cycle: data discarded, next state FETCH, new request to the target on the following cycle.
REQ-026 Redirect in FETCH with imem_valid=0: next state FLUSH.
REQ-027 FLUSH: imem_req=1 and imem_addr=old req_addr are held until imem_valid; data is discarded; then next state FETCH to the new pc.
REQ-028 Redirect in FLUSH: only pc is updated; state remains FLUSH.
REQ-029 Redirect in IDLE: pc is updated; the IDLE-to-FETCH rule is unchanged.
REQ-030 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-031 imem_valid in IDLE or HOLD is ignored.

Reset
REQ-032 With rst=0 at a clock edge: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, inst=NOP_INST, inst_pc=0, inst_valid=0, misalign=0, imem_req=0.
REQ-033 Reset SHALL override all inputs, including during FETCH or FLUSH; any in-flight response is dropped, and the memory is reset with the same rst.

Structure
REQ-034 Shared package/include fetch_pkg holds the state encoding, RESET_PC and NOP_INST defaults, and the 32'h4 increment.
REQ-035 One sub-module, pc_reg, holds pc and its next-PC mux (sequential/redirect/reset); the FSM and the output register stay in instr_fetch.

Verification
REQ-036 Reset release, memory latency 1, rdata 0x00500093, stall=0 -> req addr 0x0 on cycle 1; inst=0x00500093, inst_pc=0 and inst_valid on cycle 3; next request to 0x4.
REQ-037 stall=1 for 5 cycles in HOLD -> inst/inst_pc/inst_valid constant for 5 cycles, no imem_req; single request to 0x4 after stall drops.
REQ-038 Latency 3, redirect to 0x100 one cycle after request to 0x8 -> FLUSH, 0x8 data discarded, next request to 0x100, inst_pc=0x100.
REQ-039 Redirect to 0x202 in HOLD -> misalign pulse, inst_valid=0 next cycle, next request to 0x200.
REQ-040 Redirect to 0xFFFFFFFC, then sequential fetch -> following request to 0x00000000.
REQ-041 rst=0 asserted in FLUSH with a late imem_valid -> outputs at reset values and the response ignored; first request after release to RESET_PC.
